// File: rtl/rkold_pkg.sv
// Shared definitions for the rK-old squared-norm reader: FSM states, default widths,
// and the lane unpack helper for packed row words.
package rkold_pkg;

    localparam int unsigned EW_DEF   = 64;
    localparam int unsigned NU_DEF   = 8;
    localparam int unsigned AW_DEF   = 32;
    localparam int unsigned FRAC_DEF = 16;
    localparam int unsigned ACC_DEF  = 80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ZERO  = 2'd3
    } state_t;

    // Lane k of a default-geometry row word, as a signed element.
    function automatic logic signed [EW_DEF-1:0] lane_of(
        input logic [EW_DEF*NU_DEF-1:0] data,
        input int unsigned              k
    );
        return data[k*EW_DEF +: EW_DEF];
    endfunction

endpackage

// File: rtl/dot8_sq_tree.sv
// Two-stage squaring datapath: registered per-lane squares, then a registered adder tree
// whose sum is arithmetically scaled down by FRAC_BITS and resized to OUT_W.
module dot8_sq_tree
    import rkold_pkg::*;
#(
    parameter int EW        = 64,
    parameter int NU        = 8,
    parameter int FRAC_BITS = 16,
    parameter int OUT_W     = 80
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [EW*NU-1:0]        data_in,
    output logic                    s1_valid,
    output logic                    s2_valid,
    output logic signed [OUT_W-1:0] s2_data
);

    localparam int PW    = 2 * EW;
    localparam int SUM_W = PW + $clog2(NU) + 1;

    logic signed [PW-1:0]    sq_s   [NU];
    logic signed [PW-1:0]    prod_r [NU];
    logic                    s1_valid_r;
    logic                    s2_valid_r;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] shifted_s;
    logic signed [OUT_W-1:0] tree_out_s;
    logic signed [OUT_W-1:0] s2_data_r;

    for (genvar k = 0; k < NU; k++) begin : g_lane
        logic signed [EW-1:0] lane_s;
        logic signed [PW-1:0] ext_s;
        if (EW == EW_DEF && NU == NU_DEF) begin : g_pkg
            assign lane_s = lane_of(data_in, k);
        end else begin : g_slice
            assign lane_s = data_in[k*EW +: EW];
        end
        assign ext_s   = $signed({{EW{lane_s[EW-1]}}, lane_s});
        assign sq_s[k] = ext_s * ext_s;
    end

    // Stage 1: capture the lane squares of the row currently on the read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            for (int k = 0; k < NU; k++) begin
                prod_r[k] <= {PW{1'b0}};
            end
        end else begin
            s1_valid_r <= valid_in;
            if (valid_in) begin
                for (int k = 0; k < NU; k++) begin
                    prod_r[k] <= sq_s[k];
                end
            end
        end
    end

    // Adder tree over the registered squares, sign-extended to the guard width.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int k = 0; k < NU; k++) begin
            sum_s = sum_s + $signed({{(SUM_W-PW){prod_r[k][PW-1]}}, prod_r[k]});
        end
        shifted_s = sum_s >>> FRAC_BITS;
    end

    if (OUT_W <= SUM_W) begin : g_trunc
        assign tree_out_s = shifted_s[OUT_W-1:0];
    end else begin : g_sext
        assign tree_out_s = {{(OUT_W-SUM_W){shifted_s[SUM_W-1]}}, shifted_s};
    end

    // Stage 2: capture the scaled row sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {OUT_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= tree_out_s;
            end
        end
    end

    assign s1_valid = s1_valid_r;
    assign s2_valid = s2_valid_r;
    assign s2_data  = s2_data_r;

endmodule

// File: rtl/rkold_dot_reader.sv
// Sweeps the rK-old memory over a row range and accumulates sum(r_i*r_i) for the beta divider.
// Define RKOLD_DOT_SAT_EN for a saturating accumulator with sticky overflow; otherwise it wraps.
module rkold_dot_reader
    import rkold_pkg::*;
#(
    parameter int element_width          = EW_DEF,
    parameter int no_of_units            = NU_DEF,
    parameter int memories_address_width = AW_DEF,
    parameter int FRAC_BITS              = FRAC_DEF,
    parameter int ACC_WIDTH              = ACC_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [memories_address_width-1:0]     base_address,
    input  logic [memories_address_width-1:0]     num_rows,
    output logic [memories_address_width-1:0]     read_address,
    input  logic [element_width*no_of_units-1:0]  memory_data,
    output logic                                  busy,
    output logic                                  done,
    output logic signed [ACC_WIDTH-1:0]           result,
    output logic                                  overflow
);

    localparam int AW = memories_address_width;
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t                      state_r;
    state_t                      state_s;
    logic [AW-1:0]               read_address_r;
    logic [AW-1:0]               remain_r;
    logic                        busy_r;
    logic                        done_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] acc_next_s;
    logic                        s1_valid_s;
    logic                        s2_valid_s;
    logic signed [ACC_WIDTH-1:0] s2_data_s;
    logic                        accept_s;
    logic                        load_s;
    logic                        issue_s;
    logic                        finish_s;

    dot8_sq_tree #(
        .EW        (element_width),
        .NU        (no_of_units),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (ACC_WIDTH)
    ) u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (issue_s),
        .data_in  (memory_data),
        .s1_valid (s1_valid_s),
        .s2_valid (s2_valid_s),
        .s2_data  (s2_data_s)
    );

    assign accept_s = (state_r == ST_IDLE) && start;
    assign load_s   = accept_s && (num_rows != ADDR_ZERO);
    assign issue_s  = (state_r == ST_ISSUE);
    // The sweep ends on the edge that folds the last row in (stage 1 already empty).
    assign finish_s = ((state_r == ST_DRAIN) && s2_valid_s && !s1_valid_s) ||
                      (state_r == ST_ZERO);

    // Next-state decode for the sweep controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_rows == ADDR_ZERO) begin
                        state_s = ST_ZERO;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (remain_r == ADDR_ZERO) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (s2_valid_s && !s1_valid_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_ZERO: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Controller state, address counter, handshake flags and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            read_address_r <= ADDR_ZERO;
            remain_r       <= ADDR_ZERO;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            acc_r          <= {ACC_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (load_s) begin
                read_address_r <= base_address;
                remain_r       <= num_rows - ADDR_ONE;
            end else if (issue_s && (remain_r != ADDR_ZERO)) begin
                read_address_r <= read_address_r + ADDR_ONE;
                remain_r       <= remain_r - ADDR_ONE;
            end
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end
            done_r <= finish_s;
            if (accept_s) begin
                acc_r <= {ACC_WIDTH{1'b0}};
            end else if (s2_valid_s) begin
                acc_r <= acc_next_s;
            end
        end
    end

`ifdef RKOLD_DOT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_wide_s;
    logic                      clamp_s;
    logic                      overflow_r;

    // One guard bit exposes signed overflow; clamp toward the side the true sum lies on.
    always_comb begin
        sum_wide_s = {acc_r[ACC_WIDTH-1], acc_r} + {s2_data_s[ACC_WIDTH-1], s2_data_s};
        acc_next_s = sum_wide_s[ACC_WIDTH-1:0];
        clamp_s    = 1'b0;
        if (sum_wide_s[ACC_WIDTH] != sum_wide_s[ACC_WIDTH-1]) begin
            clamp_s    = 1'b1;
            acc_next_s = sum_wide_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            clamp_s    = 1'b0;
        end
    end

    // Sticky clamp flag, cleared when a new sweep is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            overflow_r <= 1'b0;
        end else if (s2_valid_s && clamp_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;
`else
    // Plain modular accumulate.
    always_comb begin
        acc_next_s = acc_r + s2_data_s;
    end

    assign overflow = 1'b0;
`endif

    assign read_address = read_address_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = acc_r;

endmodule
